// File: rtl/mem_access_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_arbiter_pkg : shared state and op encodings for the arbiter |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_WAIT_V = 2'b10,
    ST_WAIT_D = 2'b11
  } arb_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_access_arbiter_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, i_ptr is checked first     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                          i_req,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] i_ptr,
  output logic [NREQ-1:0]                          o_onehot,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_idx,
  output logic                                     o_any
);

  localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

  always_comb begin
    logic [c_ptr_w-1:0] w_k;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_k      = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = c_ptr_w'((int'(i_ptr) + i) % NREQ);
      if (!o_any && i_req[w_k]) begin
        o_any         = 1'b1;
        o_idx         = w_k;
        o_onehot[w_k] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_arbiter : round-robin sequencer in front of one access FSM  |
// | Optional watchdog abort: define MEM_ARB_TIMEOUT_EN.   Rev 1.0          |
// +-----------------------------------------------------------------------+
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_op,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            mem_select,
  output logic            mem_op,
  input  logic            mem_valid,
  input  logic            mem_rw
);

  localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e         r_state;
  logic [NREQ-1:0]    r_grant;
  logic [NREQ-1:0]    r_done;
  logic               r_sel;
  logic               r_mem_op;
  logic [c_ptr_w-1:0] r_ptr;
  logic [c_ptr_w-1:0] r_idx;

  logic [NREQ-1:0]    w_onehot;
  logic [c_ptr_w-1:0] w_idx;
  logic               w_any;
  logic [c_ptr_w-1:0] w_next_ptr;
  logic [1:0]         w_unused;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_next_ptr = (r_idx == c_ptr_w'(NREQ - 1)) ? '0 : r_idx + 1'b1;
  // mem_rw is informational only; the watchdog is what catches a stuck or illegal sequence.
  assign w_unused   = {mem_rw, TIMEOUT_CYC != 0};

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_sel    <= 1'b0;
      r_mem_op <= OP_READ;
      r_ptr    <= '0;
      r_idx    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_done   <= '0;
      r_sel    <= 1'b0;
      r_mem_op <= OP_READ;
      case (r_state)
        ST_IDLE: begin
          // grant is held through the done cycle and replaced (or cleared) here
          r_grant <= w_onehot;
          if (w_any) begin
            r_idx    <= w_idx;
            r_sel    <= 1'b1;
            r_mem_op <= (req_op[w_idx] == OP_WRITE) ? OP_WRITE : OP_READ;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE:  r_state <= ST_WAIT_V;
        ST_WAIT_V: if (mem_valid) r_state <= ST_WAIT_D;
        ST_WAIT_D: begin
          if (!mem_valid) begin
            r_done  <= r_grant;
            r_ptr   <= w_next_ptr;
            r_state <= ST_IDLE;
          end
        end
        default:   r_state <= ST_IDLE;
      endcase
`ifdef MEM_ARB_TIMEOUT_EN
      r_err <= 1'b0;
      r_cnt <= (r_state == ST_IDLE) ? '0 : r_cnt + 1'b1;
      // a normal completion in the same cycle takes precedence over the abort
      if ((r_state == ST_WAIT_V || (r_state == ST_WAIT_D && mem_valid)) &&
          r_cnt == c_cnt_w'(TIMEOUT_CYC - 1)) begin
        r_err   <= 1'b1;
        r_grant <= '0;
        r_ptr   <= w_next_ptr;
        r_state <= ST_IDLE;
      end
`endif
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign mem_select = r_sel;
  assign mem_op     = r_mem_op;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_access_arbiter : directed + random bench with round-robin model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mem_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_op;
  logic [3:0] grant;
  logic [3:0] done;
  logic       err;
  logic       mem_select;
  logic       mem_op;
  logic       mem_valid;
  logic       mem_rw;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  logic [10:0] outs;
  assign outs = {grant, done, err, mem_select, mem_op};

  mem_access_arbiter #(.NREQ(4), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_op     (req_op),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .mem_select (mem_select),
    .mem_op     (mem_op),
    .mem_valid  (mem_valid),
    .mem_rw     (mem_rw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {grant,done,err,sel,op}=%b expected %b", tag, obs, exp);
    end
  endtask

  // first requester at or after the pointer, walking circularly
  function automatic int exp_winner(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  task automatic run_txn(input logic [3:0] reqv, input logic [3:0] opv, input int wv,
                         input int hv, input bit keep, input int drop_c);
    int w;
    int dc;
    logic [3:0] oh;
    req       = reqv;
    req_op    = opv;
    mem_valid = 1'b0;
    w  = exp_winner(reqv, m_ptr);
    oh = 4'(1 << w);
    dc = wv + hv + 2;
    @(posedge clk); #1;
    check("issue", outs, {oh, 4'b0, 1'b0, 1'b1, opv[w]});
    for (int c = 1; c <= dc; c++) begin
      @(posedge clk); #1;
      mem_valid = (c >= 1 + wv) && (c <= wv + hv);
      mem_rw    = 1'($urandom);
      if (c == drop_c) req[w] = 1'b0;
      if (c < dc) check("busy", outs, {oh, 4'b0, 3'b0});
      else        check("done", outs, {oh, oh, 3'b0});
    end
    if (!keep) req[w] = 1'b0;
    m_ptr = (w + 1) % 4;
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    req       = 4'b1111;
    req_op    = 4'b0000;
    mem_valid = 1'b0;
    mem_rw    = 1'b0;

    repeat (2) begin
      @(posedge clk); #1;
      check("reset", outs, 11'b0);
    end
    rst = 1'b0;

    // all requesting: strict rotation 0,1,2,3,0 with alternating ops
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 4'b1010, i % 3, 1 + (i % 2), 1'b1, 0);

    // single read by requester 2 leaves the pointer at 3
    run_txn(4'b0100, 4'b0000, 0, 2, 1'b0, 0);
    // wrap from 3 to 0, then skip to 1
    run_txn(4'b1001, 4'b1001, 1, 1, 1'b0, 0);
    run_txn(4'b0001, 4'b0001, 0, 3, 1'b0, 0);
    run_txn(4'b0010, 4'b0000, 2, 1, 1'b0, 0);
    // request withdrawn mid-access still completes
    run_txn(4'b1000, 4'b1000, 1, 2, 1'b0, 2);

    for (int i = 0; i < 30; i++) begin
      run_txn(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    end

    // reset during WAIT_D abandons the access without a done pulse
    req       = 4'b0100;
    req_op    = 4'b0100;
    mem_valid = 1'b0;
    w = exp_winner(req, m_ptr);
    @(posedge clk); #1;
    check("abort_issue", outs, {4'(1 << w), 4'b0, 1'b0, 1'b1, 1'b1});
    mem_valid = 1'b1;
    @(posedge clk); #1;
    check("abort_wv", outs, {4'(1 << w), 4'b0, 3'b0});
    @(posedge clk); #1;
    check("abort_wd", outs, {4'(1 << w), 4'b0, 3'b0});
    mem_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    check("abort_rst", outs, 11'b0);
    rst = 1'b0;
    req = 4'b0000;
    m_ptr = 0;
    @(posedge clk); #1;
    check("abort_after", outs, 11'b0);

    // memory never answers: watchdog abort if built in, otherwise an indefinite wait
    req    = 4'b0001;
    req_op = 4'b0000;
    @(posedge clk); #1;
    check("hang_issue", outs, {4'b0001, 4'b0, 1'b0, 1'b1, 1'b0});
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
`ifdef MEM_ARB_TIMEOUT_EN
      if (c < 16)       check("hang_wait", outs, {4'b0001, 4'b0, 3'b0});
      else if (c == 16) check("hang_err",  outs, {4'b0, 4'b0, 1'b1, 2'b0});
      else              check("hang_idle", outs, 11'b0);
`else
      check("hang_wait", outs, {4'b0001, 4'b0, 3'b0});
`endif
      if (c == 16) req = 4'b0000;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
